// File: rtl/mips16_pkg.sv
// Shared constants for the 16-bit MIPS pipeline.
// Covers datapath widths, ALU opcodes and flag bit positions.
package mips16_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SLL = 4'h6;
  localparam logic [3:0] OP_SRL = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_is_reserved(input logic [3:0] op);
    return op > OP_CMP;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU: result, candidate {Z,N,C,V}, and whether the
// opcode is allowed to update flags at all.
module alu16
  import mips16_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    alu_op,
  output logic [DW-1:0] result,
  output logic [3:0]    flags_next,
  output logic          flag_valid
);

  logic [DW:0]   sum, diff, inc, dec;
  logic [DW:0]   sll_ext, srl_ext, sra_ext;
  logic [3:0]    shamt;
  logic [DW-1:0] res;
  logic          c, v;

  // Widened operands: bit DW carries the carry/borrow, and for shifts the
  // extra bit catches the last bit shifted out (0 when shamt is 0).
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign inc     = {1'b0, a} + 17'd1;
  assign dec     = {1'b0, a} - 17'd1;
  assign shamt   = b[3:0];
  assign sll_ext = {1'b0, a} << shamt;
  assign srl_ext = {a, 1'b0} >> shamt;
  assign sra_ext = $signed({a, 1'b0}) >>> shamt;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      OP_SUB, OP_CMP: begin
        res = diff[DW-1:0];
        c   = diff[DW];
        v   = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SLL: begin
        res = sll_ext[DW-1:0];
        c   = sll_ext[DW];
      end
      OP_SRL: begin
        res = srl_ext[DW:1];
        c   = srl_ext[0];
      end
      OP_SRA: begin
        res = sra_ext[DW:1];
        c   = sra_ext[0];
      end
      OP_MOV: res = b;
      OP_INC: begin
        res = inc[DW-1:0];
        c   = inc[DW];
        v   = ~a[DW-1] & res[DW-1];
      end
      OP_DEC: begin
        res = dec[DW-1:0];
        c   = dec[DW];
        v   = a[DW-1] & ~res[DW-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_Z] = (res == '0);
    flags_next[FLAG_N] = res[DW-1];
    flags_next[FLAG_C] = c;
    flags_next[FLAG_V] = v;
  end

  assign result     = res;
  assign flag_valid = !op_is_reserved(alu_op);

endmodule

// File: rtl/execute_stage.sv
// EX stage: B-operand mux, ALU, EX/DM pipeline register and status flags.
// Edge priority is reset > stall > flush > normal.
module execute_stage
  import mips16_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] operand_a,
  input  logic [DW-1:0] operand_b,
  input  logic [DW-1:0] imm,
  input  logic          imm_sel,
  input  logic [3:0]    alu_op,
  input  logic          mem_rw_id,
  input  logic          mem_en_id,
  input  logic          mem_mux_sel_id,
  input  logic          wb_en_id,
  input  logic [RW-1:0] rd_id,
  input  logic          flag_en_id,
  output logic [DW-1:0] ans_ex,
  output logic [DW-1:0] DM_data,
  output logic          mem_rw_ex,
  output logic          mem_en_ex,
  output logic          mem_mux_sel_dm,
  output logic          wb_en_ex,
  output logic [RW-1:0] rd_ex,
  output logic [3:0]    flags
);

  logic [DW-1:0] alu_b, alu_res;
  logic [3:0]    alu_flags;
  logic          alu_flag_valid, is_cmp;

  logic [DW-1:0] ans_q, ans_d, dm_data_q, dm_data_d;
  logic          mem_rw_q, mem_rw_d, mem_en_q, mem_en_d;
  logic          mux_sel_q, mux_sel_d, wb_en_q, wb_en_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [3:0]    flags_q, flags_d;

  assign alu_b  = imm_sel ? imm : operand_b;
  assign is_cmp = (alu_op == OP_CMP);

  alu16 u_alu (
    .a          (operand_a),
    .b          (alu_b),
    .alu_op     (alu_op),
    .result     (alu_res),
    .flags_next (alu_flags),
    .flag_valid (alu_flag_valid)
  );

  always_comb begin
    ans_d     = ans_q;
    dm_data_d = dm_data_q;
    mem_rw_d  = mem_rw_q;
    mem_en_d  = mem_en_q;
    mux_sel_d = mux_sel_q;
    wb_en_d   = wb_en_q;
    rd_d      = rd_q;
    flags_d   = flags_q;
    if (stall) begin
      // hold everything; a coincident flush is dropped
    end else if (flush) begin
      ans_d     = '0;
      dm_data_d = '0;
      mem_rw_d  = 1'b0;
      mem_en_d  = 1'b0;
      mux_sel_d = 1'b0;
      wb_en_d   = 1'b0;
      rd_d      = '0;
    end else begin
      ans_d     = alu_res;
      dm_data_d = operand_b;
      mem_rw_d  = mem_rw_id;
      mem_en_d  = mem_en_id & ~is_cmp;
      mux_sel_d = mem_mux_sel_id;
      wb_en_d   = wb_en_id & ~is_cmp;
      rd_d      = rd_id;
      if (flag_en_id && alu_flag_valid) flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q     <= '0;
      dm_data_q <= '0;
      mem_rw_q  <= 1'b0;
      mem_en_q  <= 1'b0;
      mux_sel_q <= 1'b0;
      wb_en_q   <= 1'b0;
      rd_q      <= '0;
      flags_q   <= '0;
    end else begin
      ans_q     <= ans_d;
      dm_data_q <= dm_data_d;
      mem_rw_q  <= mem_rw_d;
      mem_en_q  <= mem_en_d;
      mux_sel_q <= mux_sel_d;
      wb_en_q   <= wb_en_d;
      rd_q      <= rd_d;
      flags_q   <= flags_d;
    end
  end

  assign ans_ex         = ans_q;
  assign DM_data        = dm_data_q;
  assign mem_rw_ex      = mem_rw_q;
  assign mem_en_ex      = mem_en_q;
  assign mem_mux_sel_dm = mux_sel_q;
  assign wb_en_ex       = wb_en_q;
  assign rd_ex          = rd_q;
  assign flags          = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against an arithmetic
// reference model of the EX/DM register and flags.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [15:0] operand_a, operand_b, imm;
  logic        imm_sel;
  logic [3:0]  alu_op;
  logic        mem_rw_id, mem_en_id, mem_mux_sel_id, wb_en_id, flag_en_id;
  logic [2:0]  rd_id;
  logic [15:0] ans_ex, DM_data;
  logic        mem_rw_ex, mem_en_ex, mem_mux_sel_dm, wb_en_ex;
  logic [2:0]  rd_ex;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int unsigned m_ans, m_dm, m_rd, m_flags;
  bit          m_rw, m_en, m_mux, m_wb;

  execute_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
    .imm_sel(imm_sel), .alu_op(alu_op), .mem_rw_id(mem_rw_id),
    .mem_en_id(mem_en_id), .mem_mux_sel_id(mem_mux_sel_id),
    .wb_en_id(wb_en_id), .rd_id(rd_id), .flag_en_id(flag_en_id),
    .ans_ex(ans_ex), .DM_data(DM_data), .mem_rw_ex(mem_rw_ex),
    .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .wb_en_ex(wb_en_ex), .rd_ex(rd_ex), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed16(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  // Opcode semantics computed with plain integer arithmetic.
  task automatic ref_alu(input int unsigned op, input int unsigned a, input int unsigned b,
                         output int unsigned res, output int unsigned fl, output bit valid);
    int          sa, sb, sr;
    int unsigned s;
    bit          c, v;
    sa = to_signed16(a);
    sb = to_signed16(b);
    s  = b % 16;
    c  = 0;
    v  = 0;
    res = 0;
    valid = (op <= 12);
    case (op)
      0:  begin res = (a + b) % 65536; c = (a + b) > 65535; sr = sa + sb; v = (sr > 32767 || sr < -32768); end
      1, 12: begin res = (a - b + 65536) % 65536; c = a < b; sr = sa - sb; v = (sr > 32767 || sr < -32768); end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = 65535 - a;
      6:  begin res = (a << s) % 65536; c = (s != 0) && (((a >> (16 - s)) & 1) == 1); end
      7:  begin res = a >> s;           c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      8:  begin res = int'(sa >>> s) & 16'hFFFF; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      9:  res = b;
      10: begin res = (a + 1) % 65536; c = (a == 65535); v = (sa == 32767); end
      11: begin res = (a + 65535) % 65536; c = (a == 0); v = (sa == -32768); end
      default: res = 0;
    endcase
    fl = ((res == 0) ? 8 : 0) + ((res >= 32768) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
  endtask

  task automatic model_edge();
    int unsigned res, fl, b;
    bit          valid;
    if (reset) begin
      m_ans = 0; m_dm = 0; m_rd = 0; m_flags = 0;
      m_rw = 0; m_en = 0; m_mux = 0; m_wb = 0;
    end else if (stall) begin
    end else if (flush) begin
      m_ans = 0; m_dm = 0; m_rd = 0;
      m_rw = 0; m_en = 0; m_mux = 0; m_wb = 0;
    end else begin
      b = imm_sel ? imm : operand_b;
      ref_alu(alu_op, operand_a, b, res, fl, valid);
      m_ans = res;
      m_dm  = operand_b;
      m_rd  = rd_id;
      m_rw  = mem_rw_id;
      m_mux = mem_mux_sel_id;
      m_en  = mem_en_id && (alu_op != 12);
      m_wb  = wb_en_id && (alu_op != 12);
      if (flag_en_id && valid) m_flags = fl;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ans_ex", ans_ex, m_ans);
    check("DM_data", DM_data, m_dm);
    check("mem_rw_ex", mem_rw_ex, m_rw);
    check("mem_en_ex", mem_en_ex, m_en);
    check("mem_mux_sel_dm", mem_mux_sel_dm, m_mux);
    check("wb_en_ex", wb_en_ex, m_wb);
    check("rd_ex", rd_ex, m_rd);
    check("flags", flags, m_flags);
    $display("t=%0t rst=%0b stl=%0b fl=%0b op=%0h a=%04h b=%04h imm=%04h sel=%0b -> ans=%04h flags=%04b",
             $time, reset, stall, flush, alu_op, operand_a, operand_b, imm, imm_sel, ans_ex, flags);
  endtask

  task automatic rand_inputs();
    int unsigned k;
    k = $urandom_range(0, 3);
    operand_a = (k == 0) ? 16'h7FFF : (k == 1) ? 16'h8000 : 16'($urandom);
    k = $urandom_range(0, 3);
    operand_b = (k == 0) ? 16'h0001 : (k == 1) ? 16'hFFFF : 16'($urandom);
    imm            = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
    imm_sel        = 1'($urandom);
    alu_op         = 4'($urandom);
    mem_rw_id      = 1'($urandom);
    mem_en_id      = 1'($urandom);
    mem_mux_sel_id = 1'($urandom);
    wb_en_id       = 1'($urandom);
    rd_id          = 3'($urandom);
    flag_en_id     = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_op = op; operand_a = a; operand_b = b; imm_sel = 1'b0; flag_en_id = 1'b1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    operand_a = 16'h1234; alu_op = 4'h0; wb_en_id = 1'b1; mem_en_id = 1'b1;

    // reset with nonzero inputs, then reset alongside stall
    step(); step();
    check("rst_ans", ans_ex, 0);
    check("rst_flags", flags, 0);
    stall = 1'b1;
    step();
    check("rst_stall_wb", wb_en_ex, 0);
    reset = 1'b0; stall = 1'b0;

    // signed overflow, then borrow
    set_op(4'h0, 16'h7FFF, 16'h0001);
    step();
    check("ovf_ans", ans_ex, 16'h8000);
    check("ovf_flags", flags, 4'b0101);
    set_op(4'h1, 16'h0003, 16'h0005);
    step();
    check("sub_ans", ans_ex, 16'hFFFE);
    check("sub_flags", flags, 4'b0110);

    // store to data memory via immediate address
    set_op(4'h0, 16'h0010, 16'hFFFF);
    imm = 16'h0003; imm_sel = 1'b1; mem_en_id = 1'b1; mem_rw_id = 1'b1;
    step();
    check("st_ans", ans_ex, 16'h0013);
    check("st_dm", DM_data, 16'hFFFF);
    check("st_rw", mem_rw_ex, 1);
    check("st_en", mem_en_ex, 1);

    // stall holds, stall beats flush, flush alone bubbles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
      check("stall_hold_ans", ans_ex, 16'h0013);
    end
    flush = 1'b1;
    step();
    check("stall_flush_en", mem_en_ex, 1);
    stall = 1'b0;
    step();
    check("flush_en", mem_en_ex, 0);
    check("flush_ans", ans_ex, 0);
    flush = 1'b0;

    // shifts
    set_op(4'h8, 16'h8001, 16'h0001);
    step();
    check("sra_ans", ans_ex, 16'hC000);
    check("sra_flags", flags, 4'b0110);
    set_op(4'h6, 16'h8001, 16'h0000);
    step();
    check("sll0_ans", ans_ex, 16'h8001);
    check("sll0_c", flags[1], 0);
    set_op(4'h7, 16'h0001, 16'h0001);
    step();
    check("srl_ans", ans_ex, 0);
    check("srl_flags", flags, 4'b1010);

    // compare and reserved opcode
    set_op(4'hC, 16'h1234, 16'h1234);
    wb_en_id = 1'b1;
    step();
    check("cmp_z", flags[3], 1);
    check("cmp_wb", wb_en_ex, 0);
    set_op(4'hE, 16'h5555, 16'h1111);
    step();
    check("rsv_ans", ans_ex, 0);
    check("rsv_flags", flags, 4'b1000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
